// File: rtl/uart_packet_framer_if.sv
// Byte-stream bundle between uart_core, the packet framer and its consumer.
// master: the surrounding logic (byte source, payload sink, status observer).
// slave:  the framer itself.
interface uart_packet_framer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       packet;
  logic       err_sync;
  logic       err_crc;
  logic       err_timeout;
  logic       err_overrun;
  logic [7:0] drop_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_last, packet,
    input  err_sync, err_crc, err_timeout, err_overrun, drop_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_last, packet,
    output err_sync, err_crc, err_timeout, err_overrun, drop_count
  );
endinterface

// File: rtl/uart_packet_framer.sv
// Frames the raw UART byte stream into sync-prefixed, XOR-checked packets of
// PACKET_LEN bytes and forwards validated payloads over a valid/ready stream.
// Two ping-pong payload banks: the rx bank fills while the tx bank drains. A
// completed packet that finds the tx bank busy waits in the rx bank (pending);
// payload bytes arriving while both banks hold packets are lost, and that
// packet is reported as an overrun when its checksum byte arrives.
module uart_packet_framer #(
  parameter int unsigned PACKET_LEN     = 4,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic                 clk,
  input logic                 reset,
  uart_packet_framer_if.slave bus
);

  localparam int unsigned    PayloadLen = PACKET_LEN - 2;
  localparam int unsigned    IdxW       = (PayloadLen > 1) ? $clog2(PayloadLen) : 1;
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(PayloadLen - 1);
  localparam logic [23:0]    IdleLast   = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {RxHunt, RxBody, RxCsum} rx_state_e;
  typedef enum logic {TxEmpty, TxSend} tx_state_e;

  rx_state_e       rx_state_q, rx_state_d;
  tx_state_e       tx_state_q, tx_state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]      chk_q, chk_d;
  logic [23:0]     idle_q, idle_d;
  logic            rx_sel_q, rx_sel_d;
  logic            pending_q, pending_d;
  logic            lost_q, lost_d;
  logic            packet_q, packet_d;
  logic            err_sync_q, err_sync_d;
  logic            err_crc_q, err_crc_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_overrun_q, err_overrun_d;
  logic [7:0]      drop_q, drop_d;

  logic [7:0]      bank_q [2][PayloadLen];
  logic            wr_en;
  logic            load_tx;
  logic            err_any;
  logic            handshake;
  logic            drain_done;
  logic            tx_sel;

  logic            out_valid;
  logic [7:0]      out_data;
  logic            out_last;

  assign tx_sel     = ~rx_sel_q;
  assign handshake  = (tx_state_q == TxSend) && bus.out_ready;
  assign drain_done = handshake && (rd_idx_q == LastIdx);

  // State and control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q    <= RxHunt;
      tx_state_q    <= TxEmpty;
      idx_q         <= '0;
      rd_idx_q      <= '0;
      chk_q         <= '0;
      idle_q        <= '0;
      rx_sel_q      <= 1'b0;
      pending_q     <= 1'b0;
      lost_q        <= 1'b0;
      packet_q      <= 1'b0;
      err_sync_q    <= 1'b0;
      err_crc_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      drop_q        <= '0;
    end else begin
      rx_state_q    <= rx_state_d;
      tx_state_q    <= tx_state_d;
      idx_q         <= idx_d;
      rd_idx_q      <= rd_idx_d;
      chk_q         <= chk_d;
      idle_q        <= idle_d;
      rx_sel_q      <= rx_sel_d;
      pending_q     <= pending_d;
      lost_q        <= lost_d;
      packet_q      <= packet_d;
      err_sync_q    <= err_sync_d;
      err_crc_q     <= err_crc_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
      drop_q        <= drop_d;
    end
  end

  // Payload storage; contents only matter once a bank is marked full
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_q[rx_sel_q][idx_q] <= bus.in_data;
    end
  end

  // Next-state logic for the rx parser, tx drain and bank ownership
  always_comb begin
    rx_state_d    = rx_state_q;
    tx_state_d    = tx_state_q;
    idx_d         = idx_q;
    rd_idx_d      = rd_idx_q;
    chk_d         = chk_q;
    idle_d        = idle_q;
    rx_sel_d      = rx_sel_q;
    pending_d     = pending_q;
    lost_d        = lost_q;
    packet_d      = 1'b0;
    err_sync_d    = 1'b0;
    err_crc_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    wr_en         = 1'b0;
    load_tx       = 1'b0;

    unique case (rx_state_q)
      RxHunt: begin
        idle_d = '0;
        if (bus.in_valid) begin
          if (bus.in_data == SYNC_BYTE) begin
            chk_d      = SYNC_BYTE;
            idx_d      = '0;
            lost_d     = 1'b0;
            rx_state_d = RxBody;
          end else begin
            err_sync_d = 1'b1;
          end
        end
      end
      RxBody, RxCsum: begin
        if (bus.in_valid) begin
          // An arriving byte always beats a timeout reached in the same cycle
          idle_d = '0;
          if (rx_state_q == RxBody) begin
            chk_d = chk_q ^ bus.in_data;
            if (pending_q) begin
              lost_d = 1'b1;
            end else begin
              wr_en = 1'b1;
            end
            if (idx_q == LastIdx) begin
              rx_state_d = RxCsum;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            rx_state_d = RxHunt;
            if (bus.in_data != chk_q) begin
              err_crc_d = 1'b1;
            end else if (lost_q || pending_q) begin
              err_overrun_d = 1'b1;
            end else begin
              packet_d = 1'b1;
              // A bank freed by this cycle's final handshake counts as free
              if (tx_state_q == TxEmpty || drain_done) begin
                load_tx = 1'b1;
              end else begin
                pending_d = 1'b1;
              end
            end
          end
        end else if (idle_q == IdleLast) begin
          err_timeout_d = 1'b1;
          rx_state_d    = RxHunt;
          idle_d        = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      default: rx_state_d = RxHunt;
    endcase

    unique case (tx_state_q)
      TxEmpty: begin
        if (load_tx) begin
          tx_state_d = TxSend;
          rx_sel_d   = ~rx_sel_q;
          rd_idx_d   = '0;
        end
      end
      TxSend: begin
        if (drain_done) begin
          rd_idx_d = '0;
          if (load_tx || pending_q) begin
            rx_sel_d  = ~rx_sel_q;
            pending_d = 1'b0;
          end else begin
            tx_state_d = TxEmpty;
          end
        end else if (handshake) begin
          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      default: tx_state_d = TxEmpty;
    endcase
  end

  // Drop counter, one step per error pulse, saturating
  always_comb begin
    err_any = err_sync_d | err_crc_d | err_timeout_d | err_overrun_d;
    drop_d  = drop_q;
    if (err_any && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Output stream presents the tx bank; data forced to zero when idle
  always_comb begin
    out_valid = (tx_state_q == TxSend);
    out_data  = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data = bank_q[tx_sel][rd_idx_q];
      out_last = (rd_idx_q == LastIdx);
    end
  end

  assign bus.out_valid   = out_valid;
  assign bus.out_data    = out_data;
  assign bus.out_last    = out_last;
  assign bus.packet      = packet_q;
  assign bus.err_sync    = err_sync_q;
  assign bus.err_crc     = err_crc_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_overrun = err_overrun_q;
  assign bus.drop_count  = drop_q;

endmodule

// File: tb/tb_uart_packet_framer.sv
// Bench for uart_packet_framer: directed scenarios plus randomized packets,
// all checked against a packet-level reference model kept in queues.
module tb_uart_packet_framer;
  localparam int unsigned PLEN = 4;
  localparam int unsigned TMO  = 10;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_packet_framer_if bus_if ();

  uart_packet_framer #(
    .PACKET_LEN    (PLEN),
    .SYNC_BYTE     (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: parser state, queue of payload bytes awaiting delivery
  // ({last, data}), number of stored packets, expected pulses for next cycle.
  bit         hunting = 1'b1;
  logic [7:0] cur[$];
  int         idle    = 0;
  logic [8:0] outq[$];
  int         held    = 0;
  int         drop    = 0;
  bit         lost    = 1'b0;
  bit e_pkt, e_sync, e_crc, e_to, e_ovr;
  int         rdy_mode = 1;  // 0: never ready, 1: always ready, 2: random

  task automatic model_reset();
    hunting = 1'b1;
    cur.delete();
    idle = 0;
    outq.delete();
    held = 0;
    drop = 0;
    lost = 1'b0;
    {e_pkt, e_sync, e_crc, e_to, e_ovr} = '0;
  endtask

  task automatic model_step(input bit rst, input bit v, input logic [7:0] d, input bit r);
    int         held_pre;
    logic [7:0] x;
    logic [8:0] f;
    // Outputs visible now reflect the model state built up to this cycle
    check_eq("out_valid", bus_if.out_valid, held > 0);
    if (held > 0) begin
      check_eq("out_data", bus_if.out_data, outq[0][7:0]);
      check_eq("out_last", bus_if.out_last, outq[0][8]);
    end
    check_eq("packet", bus_if.packet, e_pkt);
    check_eq("err_sync", bus_if.err_sync, e_sync);
    check_eq("err_crc", bus_if.err_crc, e_crc);
    check_eq("err_timeout", bus_if.err_timeout, e_to);
    check_eq("err_overrun", bus_if.err_overrun, e_ovr);
    check_eq("drop_count", bus_if.drop_count, drop);

    {e_pkt, e_sync, e_crc, e_to, e_ovr} = '0;
    if (rst) begin
      model_reset();
      return;
    end
    held_pre = held;
    if (held > 0 && r) begin
      f = outq.pop_front();
      if (f[8]) held--;
    end
    if (v) begin
      idle = 0;
      if (hunting) begin
        if (d == SYNC) begin
          cur.delete();
          cur.push_back(d);
          lost    = 1'b0;
          hunting = 1'b0;
        end else begin
          e_sync = 1'b1;
        end
      end else begin
        cur.push_back(d);
        if (cur.size() < PLEN) begin
          // No room while two whole packets are still stored
          if (held_pre >= 2) lost = 1'b1;
        end else begin
          hunting = 1'b1;
          x = '0;
          for (int i = 0; i < PLEN - 1; i++) x ^= cur[i];
          if (x != d) begin
            e_crc = 1'b1;
          end else if (lost || held >= 2) begin
            e_ovr = 1'b1;
          end else begin
            for (int i = 1; i < PLEN - 1; i++) outq.push_back({(i == PLEN - 2), cur[i]});
            held++;
            e_pkt = 1'b1;
          end
        end
      end
    end else if (!hunting) begin
      idle++;
      if (idle == TMO) begin
        e_to    = 1'b1;
        hunting = 1'b1;
        idle    = 0;
      end
    end
    if (e_sync || e_crc || e_to || e_ovr) begin
      if (drop < 255) drop++;
    end
  endtask

  // One clock cycle: drive inputs, check/advance model, move to next negedge
  task automatic tick(input bit rst, input bit v, input logic [7:0] d);
    bit r;
    r = (rdy_mode == 2) ? bit'($urandom_range(0, 1)) : (rdy_mode == 1);
    reset            = rst;
    bus_if.in_valid  = v;
    bus_if.in_data   = d;
    bus_if.out_ready = r;
    model_step(rst, v, d, r);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle_cycles(gap);
    tick(1'b0, 1'b1, b);
  endtask

  task automatic send_good(input logic [7:0] p0, input logic [7:0] p1);
    send_byte(SYNC, 0);
    send_byte(p0, 0);
    send_byte(p1, 0);
    send_byte(SYNC ^ p0 ^ p1, 0);
  endtask

  task automatic rand_pkt();
    logic [7:0] b [PLEN];
    int gap;
    b[0] = SYNC;
    b[PLEN-1] = SYNC;
    for (int i = 1; i < PLEN - 1; i++) begin
      b[i] = 8'($urandom);
      b[PLEN-1] ^= b[i];
    end
    if ($urandom_range(0, 9) == 0) b[PLEN-1] ^= 8'(1 << $urandom_range(0, 7));
    if ($urandom_range(0, 9) == 0) send_byte(8'($urandom), 0);
    for (int i = 0; i < PLEN; i++) begin
      gap = ($urandom_range(0, 19) == 0) ? $urandom_range(8, 12) : $urandom_range(0, 2);
      send_byte(b[i], gap);
    end
  endtask

  initial begin
    reset            = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 8'h00;
    bus_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    tick(1'b1, 1'b0, 8'h00);  // outputs already at reset values here

    // Good packet, consumer always ready
    rdy_mode = 1;
    send_byte(8'hA5, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h83, 0);
    idle_cycles(4);

    // Bad checksum, then an all-zero payload packet
    send_byte(8'hA5, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h84, 0);
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'hA5, 0);
    idle_cycles(4);

    // Garbage before sync
    send_byte(8'h55, 0); send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
    send_byte(8'hA6, 0);
    idle_cycles(4);

    // Timeout after 10 idle cycles, then recovery
    send_byte(8'hA5, 0); send_byte(8'h12, 0);
    idle_cycles(12);
    send_good(8'h12, 8'h34);
    idle_cycles(4);

    // Byte arriving on exactly the 10th idle cycle
    send_byte(8'hA5, 0); send_byte(8'h12, 0); send_byte(8'h34, 9); send_byte(8'h83, 0);
    idle_cycles(4);

    // Backpressure: two packets banked, third overruns, then drain in order
    rdy_mode = 0;
    send_good(8'h11, 8'h22);
    send_good(8'h33, 8'h44);
    send_good(8'h55, 8'h66);
    idle_cycles(3);
    rdy_mode = 1;
    idle_cycles(8);

    // New packet completes in the same cycle as the final handshake
    rdy_mode = 0;
    send_good(8'h77, 8'h88);
    send_byte(SYNC, 0);
    send_byte(8'h99, 0);
    rdy_mode = 1;
    send_byte(8'hAA, 0);
    send_byte(SYNC ^ 8'h99 ^ 8'hAA, 0);
    idle_cycles(6);

    // Reset mid-drain
    rdy_mode = 0;
    send_byte(8'h55, 0);
    send_good(8'hC3, 8'h3C);
    idle_cycles(1);
    tick(1'b1, 1'b0, 8'h00);
    rdy_mode = 1;
    idle_cycles(2);
    send_good(8'hDE, 8'hAD);
    idle_cycles(4);

    // Randomized traffic with random gaps, errors and backpressure
    for (int n = 0; n < 250; n++) begin
      rdy_mode = ($urandom_range(0, 3) == 0) ? 0 : 2;
      rand_pkt();
    end
    rdy_mode = 1;
    idle_cycles(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
